pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential advance, jump/branch/indirect redirects and an optional return stack.
// Define PC_SEQUENCER_RAS_EN to build the return-address stack; without it jal acts as jump and ret acts as jr.
module pc_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              fetch_ready,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              jump,
    input  logic [25:0]       jump_field,
    input  logic              jal,
    input  logic              branch,
    input  logic [15:0]       branch_offset,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              ret,
    output logic              misalign,
    output logic              ras_underflow
);

    generate
        if (ADDR_W < 28 || ADDR_W > 32 || RAS_DEPTH < 2 || RAS_DEPTH > 16 || RESET_PC[1:0] != 2'b00) begin : g_bad_param
            $error("pc_sequencer: illegal parameter value");
        end
    endgenerate

    logic              advance;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] ind_raw;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_use;
    logic              uf_set;
    logic              mis_set;

    assign advance  = fetch_valid & fetch_ready & ~stall;
    assign pc_plus4 = pc + ADDR_W'(4);

    generate
        if (ADDR_W > 28) begin : g_jt_hi
            assign jump_target = {pc_plus4[ADDR_W-1:28], jump_field, 2'b00};
        end else begin : g_jt
            assign jump_target = {jump_field, 2'b00};
        end
    endgenerate

    assign branch_target = pc_plus4 + {{(ADDR_W-18){branch_offset[15]}}, branch_offset, 2'b00};

`ifdef PC_SEQUENCER_RAS_EN
    localparam int               IDX_W = $clog2(RAS_DEPTH);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(RAS_DEPTH - 1);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [IDX_W-1:0]  sp;
    logic [IDX_W-1:0]  sp_dec;
    logic [7:0]        ras_cnt;
    logic              ras_empty;
    logic              push;
    logic              pop;

    // Call depth is tracked past capacity; returns beyond it reuse the wrapped slots.
    assign sp_dec    = (sp == '0) ? LAST : sp - IDX_W'(1);
    assign ras_empty = (ras_cnt == 8'd0);
    assign ras_top   = ras_mem[sp_dec];
    assign pop       = advance & ret;
    assign push      = advance & jal & ~ret;
    assign ras_use   = ret & ~ras_empty;
    assign uf_set    = pop & ras_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp      <= '0;
            ras_cnt <= 8'd0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
        end else if (pop) begin
            if (!ras_empty) begin
                sp      <= sp_dec;
                ras_cnt <= ras_cnt - 8'd1;
            end
        end else if (push) begin
            ras_mem[sp] <= pc_plus4;
            sp          <= (sp == LAST) ? '0 : sp + IDX_W'(1);
            if (ras_cnt != 8'hFF) ras_cnt <= ras_cnt + 8'd1;
        end
    end
`else
    assign ras_top = '0;
    assign ras_use = 1'b0;
    assign uf_set  = 1'b0;
`endif

    assign ind_raw = (ret & ras_use) ? ras_top : jr_target;
    assign mis_set = advance & (ret | jr) & (ind_raw[1:0] != 2'b00);

    always_comb begin
        next_pc = pc_plus4;
        if (ret | jr)        next_pc = {ind_raw[ADDR_W-1:2], 2'b00};
        else if (jump | jal) next_pc = jump_target;
        else if (branch)     next_pc = branch_target;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc            <= RESET_PC;
            fetch_valid   <= 1'b0;
            misalign      <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            fetch_valid   <= 1'b1;
            ras_underflow <= uf_set;
            if (advance) pc <= next_pc;
            if (mis_set) misalign <= 1'b1;
        end
    end

endmodule
